serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial controller that sequences a single `full_adder` cell to add two WIDTH-bit operands plus carry-in, one bit per clock, LSB first. It sits above the 1-bit `full_adder` datapath in the adder project. It trades the area of a WIDTH-bit ripple adder for WIDTH cycles of latency, behind a start/done handshake.

## Interface
- Parameter `WIDTH`, default 5: operand and sum width in bits; legal range 2..16.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `start` input, 1: request an addition; sampled only when ready (state IDLE or DONE).
- `a` input, WIDTH: operand A; captured on the accepting edge.
- `b` input, WIDTH: operand B; captured on the accepting edge.
- `c_in` input, 1: carry-in; captured on the accepting edge.
- `busy` output, 1: high while state is RUN.
- `done` output, 1: one-cycle pulse; result is valid.
- `sum` output, WIDTH: registered result; holds until the next completed operation.
- `c_out` output, 1: registered carry-out; holds like `sum`.

## Operation
- State machine with three states: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 → RUN. Load shift registers `sa`←`a`, `sb`←`b`, carry flop←`c_in`, `bit_idx`←0.
  - `start`=0 → stay in IDLE.
- RUN, each cycle:
  - The `full_adder` gets `sa[0]`, `sb[0]` and the carry flop.
  - Its sum bit shifts into the MSB of the partial-sum register; `sa` and `sb` shift right; the carry flop←`c_out` of the cell; `bit_idx`++.
  - When `bit_idx`==WIDTH-1 on an edge, that edge also copies the completed partial sum into `sum` and the final carry into `c_out`, then → DONE.
- DONE:
  - `done`=1 for exactly this one cycle.
  - `start`=1 → RUN (back-to-back, same load as from IDLE).
  - `start`=0 → IDLE.
- `start` while RUN is ignored. Operands are not re-sampled and no error is flagged.
- Arithmetic: {`c_out`,`sum`} = `a` + `b` + `c_in`, modulo 2^(WIDTH+1). There is no overflow beyond `c_out`.
- `sum`/`c_out` never show partial values. They change only on the RUN→DONE edge.

## Timing
- Reset (async assert, any state): state=IDLE, `busy`=0, `done`=0, `sum`=0, `c_out`=0, `bit_idx`=0, shift registers and carry flop=0.
  - An operation in flight is abandoned and no `done` is produced.
- Deassertion of `rst_n` is expected to be synchronised externally.
- Latency, with `start` sampled at edge E0:
  - `busy`=1 from after E0 until edge E_WIDTH.
  - `sum`, `c_out` and `done`=1 are all valid after E_WIDTH, for one cycle.
  - For WIDTH=5, `done` is high in the 5th cycle after acceptance.
- Throughput: one result per WIDTH+1 cycles, with `start` held or re-asserted in DONE.
- `busy` and `done` are never high together. Outputs are registered; there are no combinational paths from inputs to outputs.
- Simultaneous `rst_n` low and `start`: reset wins.

## Structure
- A shared package `adder_pkg` holds:
  - state encoding constants `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2;
  - the default `WIDTH`=5.
- Encoding 2'd3 is illegal and recovers to IDLE on the next edge.
- One sub-module: the existing `full_adder` (ports `a`, `b`, `c_in`, `sum`, `c_out`), instantiated once as the serial datapath.
- The counter is $clog2(WIDTH) bits wide.

## Test plan
- `a`=7, `b`=9, `c_in`=0, `start` for one cycle → `done` pulses 5 cycles later with `sum`=16, `c_out`=0; `busy` high for 5 cycles.
- `a`=31, `b`=1, `c_in`=0 → `sum`=0, `c_out`=1. Also `a`=31, `b`=31, `c_in`=1 → `sum`=31, `c_out`=1.
- Operation in flight (`a`=3, `b`=4); in cycle 2 of RUN, drive `start`=1 with `a`=10, `b`=10 → ignored; result `sum`=7, `c_out`=0.
- Assert `rst_n`=0 in cycle 3 of RUN → immediately `busy`=0, `sum`=0, `c_out`=0; no `done` pulse afterwards.
- Back-to-back: hold `start`=1 with (`a`=1, `b`=2), then (`a`=20, `b`=15) presented in the DONE cycle → first `done` with `sum`=3; second `done` 6 cycles later with `sum`=3, `c_out`=1 (35 = 32+3).
- Exhaustive: all 2^11 (`a`, `b`, `c_in`) combinations for WIDTH=5 match the reference sum; `sum` is stable between `done` pulses.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder project: FSM state encoding and default width.
package adder_pkg;
  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the datapath that serial_adder_ctrl steps through.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: sequences one full_adder over WIDTH cycles, LSB first,
// behind a start/busy/done handshake. All outputs are registered.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa, sb, psum;
  logic             carry;
  logic [CW-1:0]    bit_idx;
  logic             fa_sum, fa_cout;

  full_adder u_fa (
    .a     (sa[0]),
    .b     (sb[0]),
    .c_in  (carry),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      sa      <= '0;
      sb      <= '0;
      psum    <= '0;
      carry   <= 1'b0;
      bit_idx <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            sa      <= a;
            sb      <= b;
            carry   <= c_in;
            psum    <= '0;
            bit_idx <= '0;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sa      <= sa >> 1;
          sb      <= sb >> 1;
          carry   <= fa_cout;
          psum    <= {fa_sum, psum[WIDTH-1:1]};
          bit_idx <= bit_idx + CW'(1);
          // Final bit: publish the whole result at once so sum never shows partials.
          if (bit_idx == LAST) begin
            sum   <= {fa_sum, psum[WIDTH-1:1]};
            c_out <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=5): latency, arithmetic,
// ignored start, mid-run reset, back-to-back and exhaustive sweep.
module tb_serial_adder_ctrl;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         c_in = 1'b0;
  logic         busy, done, c_out;
  logic [W-1:0] sum;

  int checks = 0;
  int fails  = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen or the budget runs out; reports cycles taken.
  task automatic wait_done(input int budget, output int n, output bit got);
    n = 0;
    got = 1'b0;
    while (n < budget && !got) begin
      tick();
      n++;
      got = done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({busy, done, c_out, sum} !== 8'd0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b c_out=%b sum=%0d, want all 0", busy, done, c_out, sum);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    a = 5'd7; b = 5'd9; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL basic_busy cycle %0d: busy=%b done=%b, want busy=1 done=0", k, busy, done);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== 5'd16 || c_out !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: done=%b busy=%b sum=%0d c_out=%b, want 1 0 16 0", done, busy, sum, c_out);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 5'd16) begin
      fails++;
      $display("FAIL basic_after: done=%b busy=%b sum=%0d, want 0 0 16", done, busy, sum);
    end
  endtask

  task automatic test_carry();
    int n;
    bit got;
    logic [W:0] vec [2][3];
    vec[0][0] = 6'd31; vec[0][1] = 6'd1;  vec[0][2] = 6'd0;
    vec[1][0] = 6'd31; vec[1][1] = 6'd31; vec[1][2] = 6'd1;
    for (int i = 0; i < 2; i++) begin
      a = vec[i][0][W-1:0]; b = vec[i][1][W-1:0]; c_in = vec[i][2][0]; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(20, n, got);
      checks++;
      if (!got || n != 5) begin
        fails++;
        $display("FAIL carry_latency %0d: got=%b cycles=%0d, want done after 5", i, got, n);
      end
      checks++;
      if (i == 0 && {c_out, sum} !== 6'b1_00000) begin
        fails++;
        $display("FAIL carry_31p1: c_out=%b sum=%0d, want 1 0", c_out, sum);
      end else if (i == 1 && {c_out, sum} !== 6'b1_11111) begin
        fails++;
        $display("FAIL carry_31p31p1: c_out=%b sum=%0d, want 1 31", c_out, sum);
      end
      tick();
    end
  endtask

  task automatic test_ignore_start();
    int n;
    bit got;
    a = 5'd3; b = 5'd4; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 5'd10; b = 5'd10; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20, n, got);
    checks++;
    if (!got || n != 3) begin
      fails++;
      $display("FAIL ignore_latency: got=%b cycles=%0d, want done after 3 more", got, n);
    end
    checks++;
    if (sum !== 5'd7 || c_out !== 1'b0) begin
      fails++;
      $display("FAIL ignore_result: sum=%0d c_out=%b, want 7 0", sum, c_out);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL ignore_idle: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    bit got;
    a = 5'd31; b = 5'd31; c_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || sum !== 5'd0 || c_out !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL midrun_reset: busy=%b sum=%0d c_out=%b done=%b, want all 0", busy, sum, c_out, done);
    end
    tick();
    rst_n = 1'b1;
    wait_done(10, n, got);
    checks++;
    if (got) begin
      fails++;
      $display("FAIL midrun_no_done: done seen after %0d cycles, want none", n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit got;
    a = 5'd1; b = 5'd2; c_in = 1'b0; start = 1'b1;
    tick();
    wait_done(20, n, got);
    checks++;
    if (!got || n != 5 || sum !== 5'd3 || c_out !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: got=%b cycles=%0d sum=%0d c_out=%b, want 1 5 3 0", got, n, sum, c_out);
    end
    a = 5'd20; b = 5'd15;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_restart: busy=%b done=%b, want 1 0", busy, done);
    end
    wait_done(20, n, got);
    checks++;
    if (!got || n + 1 != 6 || sum !== 5'd3 || c_out !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second: got=%b cycles=%0d sum=%0d c_out=%b, want 1 6 3 1", got, n + 1, sum, c_out);
    end
    tick();
  endtask

  task automatic test_exhaustive();
    logic [W:0] ref_v, prev;
    bit got;
    int n;
    prev = {c_out, sum};
    for (int x = 0; x < 2 ** (2 * W + 1); x++) begin
      logic [2*W:0] v;
      v = x[2*W:0];
      a = v[W-1:0]; b = v[2*W-1:W]; c_in = v[2*W];
      ref_v = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      got = 1'b0;
      while (n < 10 && !got) begin
        checks++;
        if ({c_out, sum} !== prev || (busy && done)) begin
          fails++;
          $display("FAIL exh_stable %0d: {c_out,sum}=%0d prev=%0d busy=%b done=%b", x, {c_out, sum}, prev, busy, done);
        end
        tick();
        n++;
        got = done;
      end
      checks++;
      if (!got || n != 5 || {c_out, sum} !== ref_v) begin
        fails++;
        $display("FAIL exh_result a=%0d b=%0d cin=%0d: got=%b cycles=%0d result=%0d want %0d",
                 a, b, c_in, got, n, {c_out, sum}, ref_v);
      end
      prev = ref_v;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
